// File: rtl/cpu_cycle_scheduler.sv
// CPU bus-cycle scheduler: emits cpu_en/cpu_en_m1 strobes and arbitrates the bus for DMA and DRAM refresh.
// Optional CPU_TURBO_EN: every region runs fast except $4000-$41FF, and memsel is ignored.
module cpu_cycle_scheduler #(
  parameter int unsigned FAST_LEN    = 6,
  parameter int unsigned SLOW_LEN    = 8,
  parameter int unsigned XSLOW_LEN   = 12,
  parameter int unsigned DMA_LEN     = 8,
  parameter int unsigned REFRESH_LEN = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_access,
  input  logic        memsel,
  input  logic        dma_req,
  input  logic        refresh_req,
  output logic        cpu_en,
  output logic        cpu_en_m1,
  output logic        dma_grant,
  output logic        dma_en,
  output logic        refresh_busy
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {S_CPU, S_DMA, S_REFRESH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             cpu_en_q, cpu_en_d;
  logic             cpu_en_m1_q, cpu_en_m1_d;
  logic             dma_grant_q, dma_grant_d;
  logic             dma_en_q, dma_en_d;
  logic             refresh_busy_q, refresh_busy_d;
  logic             boundary_c;
  logic [CNT_W-1:0] len_c;
  logic [15:0]      off_c;
  logic             addr_unused_c;

  assign off_c = cpu_addr[15:0];

`ifdef CPU_TURBO_EN
  assign addr_unused_c = ^{cpu_addr[23], cpu_addr[21:16], memsel};

  // Only the joypad serial window keeps its extra-slow timing.
  always_comb begin
    len_c = CNT_W'(FAST_LEN);
    if (cpu_access && !cpu_addr[22] && (off_c >= 16'h4000) && (off_c <= 16'h41FF))
      len_c = CNT_W'(XSLOW_LEN);
  end
`else
  assign addr_unused_c = ^cpu_addr[21:16];

  // Cycle length from the bank/offset region map; internal operations are always fast.
  always_comb begin
    len_c = CNT_W'(FAST_LEN);
    if (cpu_access) begin
      if (cpu_addr[22])
        len_c = (cpu_addr[23] && memsel) ? CNT_W'(FAST_LEN) : CNT_W'(SLOW_LEN);
      else if (off_c[15])
        len_c = (cpu_addr[23] && memsel) ? CNT_W'(FAST_LEN) : CNT_W'(SLOW_LEN);
      else if (off_c < 16'h2000)
        len_c = CNT_W'(SLOW_LEN);
      else if (off_c < 16'h4000)
        len_c = CNT_W'(FAST_LEN);
      else if (off_c < 16'h4200)
        len_c = CNT_W'(XSLOW_LEN);
      else if (off_c < 16'h6000)
        len_c = CNT_W'(FAST_LEN);
      else
        len_c = CNT_W'(SLOW_LEN);
    end
  end
`endif

  // Next state; the >= compare ends a cycle whose length shrank under the counter.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CNT_W'(1);
    pend_d         = pend_q | refresh_req;
    boundary_c     = 1'b0;
    cpu_en_d       = 1'b0;
    cpu_en_m1_d    = 1'b0;
    dma_en_d       = 1'b0;
    dma_grant_d    = (state_q == S_DMA);
    refresh_busy_d = (state_q == S_REFRESH);
    case (state_q)
      S_CPU: begin
        cpu_en_m1_d = (cnt_q == len_c - CNT_W'(2));
        if (cnt_q >= len_c - CNT_W'(1)) begin
          cpu_en_d   = 1'b1;
          boundary_c = 1'b1;
        end
      end
      S_DMA: begin
        if (cnt_q == CNT_W'(DMA_LEN - 1)) begin
          dma_en_d   = 1'b1;
          boundary_c = 1'b1;
        end
      end
      S_REFRESH: begin
        if (cnt_q == CNT_W'(REFRESH_LEN - 1)) begin
          cnt_d   = '0;
          state_d = dma_req ? S_DMA : S_CPU;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_CPU;
      end
    endcase
    if (boundary_c) begin
      cnt_d = '0;
      if (pend_q) begin
        state_d = S_REFRESH;
        pend_d  = 1'b0;
      end else if (dma_req) begin
        state_d = S_DMA;
      end else begin
        state_d = S_CPU;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_CPU;
      cnt_q          <= '0;
      pend_q         <= 1'b0;
      cpu_en_q       <= 1'b0;
      cpu_en_m1_q    <= 1'b0;
      dma_grant_q    <= 1'b0;
      dma_en_q       <= 1'b0;
      refresh_busy_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      cpu_en_q       <= cpu_en_d;
      cpu_en_m1_q    <= cpu_en_m1_d;
      dma_grant_q    <= dma_grant_d;
      dma_en_q       <= dma_en_d;
      refresh_busy_q <= refresh_busy_d;
    end
  end

  assign cpu_en       = cpu_en_q;
  assign cpu_en_m1    = cpu_en_m1_q;
  assign dma_grant    = dma_grant_q;
  assign dma_en       = dma_en_q;
  assign refresh_busy = refresh_busy_q;

endmodule

// File: tb/tb_cpu_cycle_scheduler.sv
// Bench for cpu_cycle_scheduler: region-length table, hand-written DMA/refresh/reset sequences, random run vs reference model.
module tb_cpu_cycle_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] cpu_addr;
  logic        cpu_access, memsel, dma_req, refresh_req;
  logic        cpu_en, cpu_en_m1, dma_grant, dma_en, refresh_busy;

  int checks = 0;
  int errors = 0;

`ifdef CPU_TURBO_EN
  localparam int SLOW_P = 6;
`else
  localparam int SLOW_P = 8;
`endif

  always #5 clk = ~clk;

  cpu_cycle_scheduler dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_access(cpu_access),
    .memsel(memsel), .dma_req(dma_req), .refresh_req(refresh_req),
    .cpu_en(cpu_en), .cpu_en_m1(cpu_en_m1), .dma_grant(dma_grant),
    .dma_en(dma_en), .refresh_busy(refresh_busy)
  );

  // Reference model: who owns the bus, clocks elapsed in its current cycle, pending refresh.
  typedef enum int {O_CPU, O_DMA, O_REF} owner_t;
  owner_t     m_owner;
  int         m_el;
  bit         m_pend;
  logic [4:0] exp_o;   // {cpu_en, cpu_en_m1, dma_grant, dma_en, refresh_busy}

  function automatic int ref_len(logic [23:0] a, logic acc, logic ms);
    int bank = int'(a[23:16]);
    int off  = int'(a[15:0]);
    if (!acc) return 6;
`ifdef CPU_TURBO_EN
    if ((bank < 'h40 || (bank >= 'h80 && bank < 'hC0)) && off >= 'h4000 && off < 'h4200) return 12;
    if (ms === 1'bx) return 6;
    return 6;
`else
    if (bank >= 'h40 && bank < 'h80) return 8;
    if (bank >= 'hC0) return ms ? 6 : 8;
    if (off < 'h2000) return 8;
    if (off < 'h4000) return 6;
    if (off < 'h4200) return 12;
    if (off < 'h6000) return 6;
    if (off < 'h8000) return 8;
    return (bank >= 'h80 && ms) ? 6 : 8;
`endif
  endfunction

  function automatic void model_reset();
    m_owner = O_CPU;
    m_el    = 0;
    m_pend  = 1'b0;
    exp_o   = '0;
  endfunction

  function automatic void model_edge();
    int     len;
    bit     fin, refdone;
    owner_t nxt;
    if (!reset_n) begin
      model_reset();
      return;
    end
    len     = ref_len(cpu_addr, cpu_access, memsel);
    exp_o   = '0;
    fin     = 1'b0;
    refdone = 1'b0;
    nxt     = m_owner;
    case (m_owner)
      O_CPU: begin
        exp_o[3] = (m_el + 2 == len);
        if (m_el + 1 >= len) begin exp_o[4] = 1'b1; fin = 1'b1; end
      end
      O_DMA: begin
        exp_o[2] = 1'b1;
        if (m_el + 1 == 8) begin exp_o[1] = 1'b1; fin = 1'b1; end
      end
      default: begin
        exp_o[0] = 1'b1;
        if (m_el + 1 == 40) begin refdone = 1'b1; nxt = dma_req ? O_DMA : O_CPU; end
      end
    endcase
    if (fin) nxt = m_pend ? O_REF : (dma_req ? O_DMA : O_CPU);
    m_pend  = (fin && m_pend) ? 1'b0 : (m_pend || refresh_req);
    m_el    = (fin || refdone) ? 0 : m_el + 1;
    m_owner = nxt;
  endfunction

  function automatic void check_val(string tag, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, expv, $time);
    end
  endfunction

  function automatic void check_outs(string tag);
    logic [4:0] act;
    act = {cpu_en, cpu_en_m1, dma_grant, dma_en, refresh_busy};
    checks++;
    if (act !== exp_o) begin
      errors++;
      $display("FAIL %s: outs {en,m1,grant,dma_en,busy} got %b, expected %b (t=%0t)", tag, act, exp_o, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outs("model");
  endtask

  function automatic logic sel(int which);
    case (which)
      0:       return cpu_en;
      1:       return dma_en;
      default: return cpu_en_m1;
    endcase
  endfunction

  // Ticks until the selected strobe is seen; n = -1 if the budget runs out.
  task automatic wait_evt(input int which, input int max_ticks, output int n);
    n = -1;
    for (int i = 1; i <= max_ticks; i++) begin
      tick();
      if (sel(which)) begin n = i; break; end
    end
  endtask

  typedef struct {
    logic [23:0] addr;
    logic        acc;
    logic        ms;
    int          per_norm;
    int          per_turbo;
  } vec_t;

  vec_t        vecs[14];
  logic [23:0] pool[13] = '{24'h7E0000, 24'h001234, 24'h002100, 24'h004016, 24'h0041FF, 24'h004200,
                            24'h006000, 24'h00FFFC, 24'h80FFFC, 24'hC00000, 24'h400000, 24'hBF8000, 24'h3F4100};

  initial begin
    int n, busy_n, en_n, grant_at;
    vecs[0]  = '{24'h7E0000, 1'b1, 1'b0, 8, 6};
    vecs[1]  = '{24'h00FFFC, 1'b1, 1'b0, 8, 6};
    vecs[2]  = '{24'h80FFFC, 1'b1, 1'b1, 6, 6};
    vecs[3]  = '{24'h004016, 1'b1, 1'b0, 12, 12};
    vecs[4]  = '{24'h000100, 1'b1, 1'b1, 8, 6};
    vecs[5]  = '{24'h002100, 1'b1, 1'b0, 6, 6};
    vecs[6]  = '{24'h004200, 1'b1, 1'b0, 6, 6};
    vecs[7]  = '{24'h006000, 1'b1, 1'b1, 8, 6};
    vecs[8]  = '{24'hC00000, 1'b1, 1'b1, 6, 6};
    vecs[9]  = '{24'hC00000, 1'b1, 1'b0, 8, 6};
    vecs[10] = '{24'h400000, 1'b1, 1'b1, 8, 6};
    vecs[11] = '{24'h8041FF, 1'b1, 1'b1, 12, 12};
    vecs[12] = '{24'h00FFFC, 1'b1, 1'b1, 8, 6};
    vecs[13] = '{24'h7E0000, 1'b0, 1'b0, 6, 6};

    reset_n = 1'b0; cpu_addr = '0; cpu_access = 1'b0; memsel = 1'b0;
    dma_req = 1'b0; refresh_req = 1'b0;
    model_reset();
    repeat (3) tick();
    check_val("reset_outs", int'({cpu_en, cpu_en_m1, dma_grant, dma_en, refresh_busy}), 0);

    // Release reset: first strobes after a full fast cycle.
    @(negedge clk); reset_n = 1'b1;
    wait_evt(2, 20, n); check_val("first_m1", n, 5);
    wait_evt(0, 20, n); check_val("first_cpu_en", n, 1);
    wait_evt(0, 20, n); check_val("period_idle", n, 6);

    // Region/length table, one CPU cycle per entry.
    foreach (vecs[i]) begin
      cpu_addr = vecs[i].addr; cpu_access = vecs[i].acc; memsel = vecs[i].ms;
      wait_evt(0, 40, n);
`ifdef CPU_TURBO_EN
      check_val($sformatf("period_%06h", vecs[i].addr), n, vecs[i].per_turbo);
`else
      check_val($sformatf("period_%06h", vecs[i].addr), n, vecs[i].per_norm);
`endif
    end

    // DMA raised mid-cycle: cycle completes, 3 transfers, then release.
    cpu_addr = 24'h7E0000; cpu_access = 1'b1; memsel = 1'b0;
    repeat (3) tick();
    dma_req = 1'b1;
    wait_evt(0, 40, n);  check_val("dma_cpu_done", n, SLOW_P - 3);
    check_val("grant_at_boundary", int'(dma_grant), 0);
    tick();              check_val("grant_next", int'(dma_grant), 1);
    wait_evt(1, 40, n);  check_val("dma_first", n, 7);
    wait_evt(1, 40, n);  check_val("dma_second", n, 8);
    dma_req = 1'b0;
    wait_evt(1, 40, n);  check_val("dma_third", n, 8);
    tick();              check_val("dma_release", int'(dma_grant), 0);
    wait_evt(0, 40, n);  check_val("cpu_after_dma", n, SLOW_P - 1);

    // Refresh pulse together with DMA request: refresh first, then DMA.
    repeat (2) tick();
    refresh_req = 1'b1; dma_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    wait_evt(0, 40, n);  check_val("ref_cpu_done", n, SLOW_P - 3);
    busy_n = 0; en_n = 0; grant_at = -1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (refresh_busy) busy_n++;
      if (cpu_en || dma_en) en_n++;
      if (dma_grant && grant_at < 0) grant_at = i;
    end
    check_val("refresh_len", busy_n, 40);
    check_val("refresh_no_en", en_n, 0);
    check_val("grant_after_refresh", grant_at, 41);
    dma_req = 1'b0;
    wait_evt(1, 20, n);  check_val("dma_after_refresh", n, 3);
    wait_evt(0, 40, n);  check_val("cpu_after_refresh", n, SLOW_P);

    // Asynchronous reset in the middle of a DMA cycle (cnt = 3).
    dma_req = 1'b1;
    wait_evt(0, 40, n);  check_val("pre_reset_cycle", n, SLOW_P);
    repeat (3) tick();
    check_val("grant_pre_reset", int'(dma_grant), 1);
    #2; reset_n = 1'b0; dma_req = 1'b0; cpu_access = 1'b0;
    model_reset();
    #1; check_outs("async_reset");
    tick();
    @(negedge clk); reset_n = 1'b1;
    wait_evt(0, 20, n);  check_val("cpu_after_reset", n, 6);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ((exp_o[4] && $urandom_range(0, 1) == 1) || $urandom_range(0, 299) == 0) begin
        cpu_addr   = pool[$urandom_range(0, 12)];
        cpu_access = ($urandom_range(0, 4) != 0);
        memsel     = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 39) == 0) dma_req = ~dma_req;
      refresh_req = ($urandom_range(0, 79) == 0);
    end
    dma_req = 1'b0; refresh_req = 1'b0;
    repeat (60) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
